// File: rtl/radar_pulse_sequencer_pkg.sv
// Shared constants, state encoding and header word layout for the radar pulse sequencer.
package radar_pulse_sequencer_pkg;

    localparam int          DEF_HDR_WORDS = 4;
    localparam int          DEF_DLY_W     = 16;
    localparam int          DEF_NS_W      = 16;
    localparam logic [15:0] HDR_MAGIC     = 16'hA5A5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_HEADER,
        ST_SAMPLES
    } seq_state_t;

    // Header layout: magic, pulse number (lo, hi), samples that follow.
    function automatic logic [15:0] hdr_word(input logic [1:0]  idx,
                                             input logic [31:0] cnt,
                                             input logic [15:0] ns);
        case (idx)
            2'd0:    hdr_word = HDR_MAGIC;
            2'd1:    hdr_word = cnt[15:0];
            2'd2:    hdr_word = cnt[31:16];
            default: hdr_word = ns;
        endcase
    endfunction

endpackage

// File: rtl/radar_pulse_sequencer.sv
// Per-pulse controller feeding the RX FIFO: trigger -> delay -> 4-word header -> N samples.
module radar_pulse_sequencer
    import radar_pulse_sequencer_pkg::*;
#(
    parameter int HDR_WORDS = DEF_HDR_WORDS,
    parameter int DLY_W     = DEF_DLY_W,
    parameter int NS_W      = DEF_NS_W
) (
    input  logic             rxclk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             trig,
    input  logic [DLY_W-1:0] trig_delay,
    input  logic [NS_W-1:0]  n_samples,
    input  logic [7:0]       pulse_skip,
    input  logic [15:0]      sample_in,
    input  logic             sample_strobe,
    input  logic             ff_full,
    input  logic             clear_status,
    output logic             ff_init,
    output logic [31:0]      ff_num_data,
    output logic [15:0]      ff_data,
    output logic             ff_strobe,
    output logic             busy,
    output logic             missed_trig,
    output logic [31:0]      trig_count
);

    seq_state_t       state, state_nxt;
    logic             trig_d;
    logic [7:0]       skip_cnt;
    logic [DLY_W-1:0] dly;
    logic [1:0]       hdr_idx;
    logic [NS_W-1:0]  ns_lat;
    logic [NS_W-1:0]  remaining;

    logic             trig_edge, accept, skip_one;
    logic             hdr_emit, hdr_last, smp_emit, smp_last;
    logic             ff_init_nxt, ff_strobe_nxt;
    logic [15:0]      ff_data_nxt;

    assign trig_edge = trig & ~trig_d;
    assign busy      = (state == ST_DELAY) || (state == ST_HEADER) || (state == ST_SAMPLES);
    assign accept    = enable && (state == ST_ARMED) && trig_edge && (skip_cnt == 8'd0);
    assign skip_one  = enable && (state == ST_ARMED) && trig_edge && (skip_cnt != 8'd0);

    // Word 0 is issued on the last delay cycle so it is on the bus in the first HEADER cycle.
    assign hdr_emit  = enable && !ff_full &&
                       (((state == ST_DELAY) && (dly == '0)) || (state == ST_HEADER));
    assign hdr_last  = hdr_emit && (hdr_idx == 2'd3);
    assign smp_emit  = enable && (state == ST_SAMPLES) && sample_strobe && !ff_full;
    assign smp_last  = smp_emit && (remaining == NS_W'(1));

    always_ff @(posedge rxclk) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_ARMED;
                ST_ARMED:   if (accept) state_nxt = ST_DELAY;
                ST_DELAY:   if (dly == '0) state_nxt = ST_HEADER;
                ST_HEADER:  if (hdr_last) state_nxt = (ns_lat == '0) ? ST_ARMED : ST_SAMPLES;
                ST_SAMPLES: if (smp_last) state_nxt = ST_ARMED;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ff_init_nxt   = accept;
        ff_strobe_nxt = hdr_emit | smp_emit;
        ff_data_nxt   = ff_data;
        if (smp_emit)
            ff_data_nxt = sample_in;
        else if (hdr_emit)
            ff_data_nxt = hdr_word(hdr_idx, trig_count, ns_lat[15:0]);
    end

    always_ff @(posedge rxclk) begin
        if (!reset_n) begin
            ff_init   <= 1'b0;
            ff_strobe <= 1'b0;
            ff_data   <= '0;
        end else begin
            ff_init   <= ff_init_nxt;
            ff_strobe <= ff_strobe_nxt;
            ff_data   <= ff_data_nxt;
        end
    end

    // Pulse configuration is captured only on accept; later changes wait for the next pulse.
    always_ff @(posedge rxclk) begin
        if (!reset_n) begin
            trig_d      <= 1'b0;
            skip_cnt    <= '0;
            dly         <= '0;
            hdr_idx     <= '0;
            ns_lat      <= '0;
            remaining   <= '0;
            ff_num_data <= '0;
            trig_count  <= '0;
            missed_trig <= 1'b0;
        end else begin
            trig_d <= trig;

            if (accept) begin
                skip_cnt    <= pulse_skip;
                dly         <= trig_delay;
                ns_lat      <= n_samples;
                hdr_idx     <= '0;
                ff_num_data <= 32'(HDR_WORDS) + 32'(n_samples);
                trig_count  <= trig_count + 32'd1;
            end else if (skip_one) begin
                skip_cnt <= skip_cnt - 8'd1;
            end

            if ((state == ST_DELAY) && (dly != '0))
                dly <= dly - DLY_W'(1);

            if (hdr_emit)
                hdr_idx <= hdr_idx + 2'd1;

            if (hdr_last)
                remaining <= ns_lat;
            else if (smp_emit)
                remaining <= remaining - NS_W'(1);

            if (trig_edge && busy)
                missed_trig <= 1'b1;
            else if (clear_status)
                missed_trig <= 1'b0;
        end
    end

endmodule
